// File: rtl/fifo_write_arbiter_pkg.sv
// fifo_arb_pkg: shared state type and ID-width helper for the FIFO write arbiter
//   arb_state_t : IDLE (arbitration cycle) / BURST (grant active)
//   id_w(n)     : bits needed to index n requesters (minimum 1)
package fifo_arb_pkg;
    typedef enum logic {IDLE, BURST} arb_state_t;
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/fifo_write_arbiter_if.sv
// fifo_write_arbiter_if: requester/FIFO-write bundle of the write arbiter
//   req_valid/req_data/req_last/req_ready : per-requester handshake, slice i = [i*WIDTH +: WIDTH]
//   fifo_write_en/fifo_write_data/fifo_full : FIFO write port
//   grant_valid/grant_id : current burst grant
//   master = arbiter side, slave = producers + FIFO side
interface fifo_write_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    localparam int IW = id_w(NUM_REQ);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_last;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     fifo_write_en;
    logic [WIDTH-1:0]         fifo_write_data;
    logic                     fifo_full;
    logic                     grant_valid;
    logic [IW-1:0]            grant_id;
    modport master (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_write_en, fifo_write_data, grant_valid, grant_id
    );
    modport slave (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_write_en, fifo_write_data, grant_valid, grant_id
    );
endinterface

// File: rtl/fifo_write_arbiter_picker.sv
// rr_priority_picker: combinational round-robin search over a request vector
//   req        : request bits
//   last_grant : previous winner; search starts at last_grant+1 with wrap
//   found      : any request set
//   winner     : index of first set request in round-robin order
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    localparam int IW      = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_grant,
    output logic               found,
    output logic [IW-1:0]      winner
);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    int                   start;
    // Rotate so the search origin sits at bit 0, take the lowest set bit,
    // then map the position back to a requester index.
    always_comb begin
        start  = (int'(last_grant) + 1) % NUM_REQ;
        dbl    = {req, req};
        rot    = dbl[start +: NUM_REQ];
        found  = |rot;
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (rot[k]) winner = IW'((k + start) % NUM_REQ);
    end
endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin burst arbiter sharing one FIFO write port
//   wr_clk : write-domain clock
//   reset  : asynchronous active-high reset
//   bus    : fifo_write_arbiter_if.master (requester handshakes, FIFO write port, grant status)
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input logic               wr_clk,
    input logic               reset,
    fifo_write_arbiter_if.master bus
);
    localparam int IW = id_w(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    arb_state_t    state;
    logic [IW-1:0] gid, last_grant, winner;
    logic [BW-1:0] beat_cnt;
    logic          gv, found, accept, done;
    rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_pick (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .found      (found),
        .winner     (winner)
    );
    // Write path is combinational so a beat is accepted and written on the same edge.
    assign accept              = state == BURST && bus.req_valid[gid] && !bus.fifo_full;
    assign done                = accept && (bus.req_last[gid] || beat_cnt == BW'(MAX_BURST - 1));
    assign bus.req_ready       = (state == BURST && !bus.fifo_full) ? NUM_REQ'(1) << gid : '0;
    assign bus.fifo_write_en   = accept;
    assign bus.fifo_write_data = bus.req_data[gid*WIDTH +: WIDTH];
    assign bus.grant_valid     = gv;
    assign bus.grant_id        = gid;
    always_ff @(posedge wr_clk or posedge reset)
        if (reset) begin
            state      <= IDLE;
            gv         <= 1'b0;
            gid        <= '0;
            beat_cnt   <= '0;
            last_grant <= IW'(NUM_REQ - 1);
        end else if (state == IDLE) begin
            if (found) begin
                state    <= BURST;
                gv       <= 1'b1;
                gid      <= winner;
                beat_cnt <= '0;
            end
        end else if (done) begin
            state      <= IDLE;
            gv         <= 1'b0;
            last_grant <= gid;
            beat_cnt   <= '0;
        end else if (accept)
            beat_cnt <= beat_cnt + 1'b1;
endmodule
